// File: rtl/nibble_word_packer_pkg.sv
// Shared sizing and state encoding for the nibble-to-word packer.
package nib_pack_pkg;
  localparam int NIB_W      = 4;
  localparam int NUM_NIBS   = 4;
  localparam int FIFO_DEPTH = 2;

  localparam int WORD_W = NIB_W * NUM_NIBS;
  localparam int CNT_W  = $clog2(NUM_NIBS + 1);
  localparam int LVL_W  = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {ACC, FLUSH_PEND} state_e;
endpackage

// File: rtl/nibble_word_packer_if.sv
// Nibble-in / word-out handshake bundle; slave is the packer's view.
interface nibble_word_packer_if;
  import nib_pack_pkg::*;

  logic              nib_valid;
  logic [NIB_W-1:0]  nib_data;
  logic              nib_ready;
  logic              flush;
  logic              word_valid;
  logic [WORD_W-1:0] word_data;
  logic [CNT_W-1:0]  word_count;
  logic              word_ready;
  logic [LVL_W-1:0]  fifo_level;

  modport slave (
    input  nib_valid, nib_data, flush, word_ready,
    output nib_ready, word_valid, word_data, word_count, fifo_level
  );

  modport master (
    output nib_valid, nib_data, flush, word_ready,
    input  nib_ready, word_valid, word_data, word_count, fifo_level
  );
endinterface

// File: rtl/nibble_word_packer_fifo.sv
// Small synchronous FIFO for completed words; simultaneous push/pop keeps level.
module nib_word_fifo #(
  parameter int W     = 19,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [W-1:0]                 wdata,
  input  logic                         pop,
  output logic [W-1:0]                 rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][W-1:0] r_mem;
  logic [AW-1:0]           r_wptr, r_rptr;
  logic [LW-1:0]           r_level;
  logic                    w_push, w_pop;

  assign full   = (r_level == LW'(DEPTH));
  assign empty  = (r_level == '0);
  assign level  = r_level;
  assign rdata  = r_mem[r_rptr];
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  // Storage is cleared on reset so the head reads zero while empty after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= wdata;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end
endmodule

// File: rtl/nibble_word_packer.sv
// Packs slicer nibbles LSB-first into words; flush emits a zero-padded partial word.
module nibble_word_packer
  import nib_pack_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  nibble_word_packer_if.slave  bus
);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_NIBS - 1);

  state_e                         r_state, w_state_nxt;
  logic [NUM_NIBS-1:0][NIB_W-1:0] r_acc, w_word;
  logic [CNT_W-1:0]               r_fill, w_cnt;
  logic                           w_accept, w_last, w_has_data;
  logic                           w_push, w_pop, w_full, w_empty;
  logic [WORD_W+CNT_W-1:0]        w_rdata;

  // No pop look-ahead: a full FIFO blocks the completing nibble even while popping.
  assign bus.nib_ready = rst_n & (r_state == ACC) & ((r_fill < LAST_IDX) | ~w_full);

  assign w_accept   = bus.nib_valid & bus.nib_ready;
  assign w_last     = w_accept & (r_fill == LAST_IDX);
  assign w_cnt      = r_fill + CNT_W'(w_accept);
  assign w_has_data = w_accept | (r_fill != '0);
  assign w_pop      = bus.word_valid & bus.word_ready;

  // Outgoing word: held slots below fill, the nibble arriving now, zeros above.
  always_comb begin
    w_word = '0;
    for (int k = 0; k < NUM_NIBS; k++) begin
      if (CNT_W'(k) < r_fill)                    w_word[k] = r_acc[k];
      else if ((CNT_W'(k) == r_fill) && w_accept) w_word[k] = bus.nib_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ACC;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ACC:        if (bus.flush & w_has_data & ~w_last & w_full) w_state_nxt = FLUSH_PEND;
      FLUSH_PEND: if (~w_full) w_state_nxt = ACC;
      default:    w_state_nxt = ACC;
    endcase
  end

  always_comb begin
    w_push = 1'b0;
    case (r_state)
      ACC:        w_push = w_last | (bus.flush & w_has_data & ~w_full);
      FLUSH_PEND: w_push = ~w_full;
      default:    w_push = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fill <= '0;
      r_acc  <= '0;
    end else if (w_push) begin
      r_fill <= '0;
    end else if (w_accept) begin
      r_fill <= r_fill + CNT_W'(1);
      for (int k = 0; k < NUM_NIBS; k++)
        if (CNT_W'(k) == r_fill) r_acc[k] <= bus.nib_data;
    end
  end

  nib_word_fifo #(
    .W     (WORD_W + CNT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .wdata ({w_cnt, w_word}),
    .pop   (w_pop),
    .rdata (w_rdata),
    .full  (w_full),
    .empty (w_empty),
    .level (bus.fifo_level)
  );

  assign bus.word_valid = ~w_empty;
  assign bus.word_data  = w_rdata[WORD_W-1:0];
  assign bus.word_count = w_rdata[WORD_W +: CNT_W];
endmodule

// File: tb/tb_nibble_word_packer.sv
// Directed vector bench for nibble_word_packer: table rows plus multi-cycle sequences.
module tb_nibble_word_packer;
  import nib_pack_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  nibble_word_packer_if bus();
  nibble_word_packer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic        nv;
    logic [3:0]  nd;
    logic        fl;
    logic        wr;
    logic        rdy;
    logic        wv;
    logic [15:0] d;
    logic [2:0]  c;
    logic [1:0]  lvl;
  } vec_t;

  int n_run  = 0;
  int n_fail = 0;

  function automatic vec_t mk(logic nv, logic [3:0] nd, logic fl, logic wr,
                              logic rdy, logic wv, logic [15:0] d, logic [2:0] c,
                              logic [1:0] lvl);
    vec_t v;
    v.nv = nv; v.nd = nd; v.fl = fl; v.wr = wr;
    v.rdy = rdy; v.wv = wv; v.d = d; v.c = c; v.lvl = lvl;
    return v;
  endfunction

  task automatic chk(string tag, int idx, string fld, logic [31:0] act, logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] %s: got %0h expected %0h", tag, idx, fld, act, exp);
    end
  endtask

  // Drive one cycle's inputs, check the pre-edge outputs, then advance past the edge.
  task automatic apply(string tag, int idx, vec_t v);
    bus.nib_valid  = v.nv;
    bus.nib_data   = v.nd;
    bus.flush      = v.fl;
    bus.word_ready = v.wr;
    #2;
    chk(tag, idx, "nib_ready",  32'(bus.nib_ready),  32'(v.rdy));
    chk(tag, idx, "word_valid", 32'(bus.word_valid), 32'(v.wv));
    chk(tag, idx, "fifo_level", 32'(bus.fifo_level), 32'(v.lvl));
    if (v.wv) begin
      chk(tag, idx, "word_data",  32'(bus.word_data),  32'(v.d));
      chk(tag, idx, "word_count", 32'(bus.word_count), 32'(v.c));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_seq(string tag, vec_t q[$]);
    foreach (q[i]) apply(tag, i, q[i]);
  endtask

  task automatic chk_reset_outs(string tag);
    chk(tag, 0, "nib_ready",  32'(bus.nib_ready),  32'd0);
    chk(tag, 0, "word_valid", 32'(bus.word_valid), 32'd0);
    chk(tag, 0, "word_data",  32'(bus.word_data),  32'd0);
    chk(tag, 0, "word_count", 32'(bus.word_count), 32'd0);
    chk(tag, 0, "fifo_level", 32'(bus.fifo_level), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    vec_t q[$];

    bus.nib_valid = 1'b0; bus.nib_data = '0; bus.flush = 1'b0; bus.word_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outs("reset");
    rst_n = 1'b1;

    // Full word, partial flush with stale accumulator slots, no-op flush, flush+accept at fill 0
    tbl.push_back(mk(1, 4'h1, 0, 1,  1, 0, 16'h0000, 3'd0, 2'd0));
    tbl.push_back(mk(1, 4'h2, 0, 1,  1, 0, 16'h0000, 3'd0, 2'd0));
    tbl.push_back(mk(1, 4'h3, 0, 1,  1, 0, 16'h0000, 3'd0, 2'd0));
    tbl.push_back(mk(1, 4'h4, 0, 1,  1, 0, 16'h0000, 3'd0, 2'd0));
    tbl.push_back(mk(0, 4'h0, 0, 1,  1, 1, 16'h4321, 3'd4, 2'd1));
    tbl.push_back(mk(1, 4'hA, 0, 0,  1, 0, 16'h0000, 3'd0, 2'd0));
    tbl.push_back(mk(1, 4'hB, 0, 0,  1, 0, 16'h0000, 3'd0, 2'd0));
    tbl.push_back(mk(0, 4'h0, 1, 0,  1, 0, 16'h0000, 3'd0, 2'd0));
    tbl.push_back(mk(0, 4'h0, 0, 1,  1, 1, 16'h00BA, 3'd2, 2'd1));
    tbl.push_back(mk(0, 4'h0, 1, 1,  1, 0, 16'h0000, 3'd0, 2'd0));
    tbl.push_back(mk(0, 4'h0, 0, 1,  1, 0, 16'h0000, 3'd0, 2'd0));
    tbl.push_back(mk(1, 4'h7, 1, 0,  1, 0, 16'h0000, 3'd0, 2'd0));
    tbl.push_back(mk(0, 4'h0, 0, 1,  1, 1, 16'h0007, 3'd1, 2'd1));
    tbl.push_back(mk(0, 4'h0, 0, 0,  1, 0, 16'h0000, 3'd0, 2'd0));
    foreach (tbl[i]) apply("table", i, tbl[i]);

    // Backpressure: two words fill the FIFO, completing nibble of the third waits
    q = {};
    for (int i = 0; i < 8; i++)
      q.push_back(mk(1, 4'(i + 1), 0, 0, 1, (i >= 4), 16'h4321, 3'd4, (i >= 4) ? 2'd1 : 2'd0));
    q.push_back(mk(1, 4'h9, 0, 0,  1, 1, 16'h4321, 3'd4, 2'd2));
    q.push_back(mk(1, 4'hA, 0, 0,  1, 1, 16'h4321, 3'd4, 2'd2));
    q.push_back(mk(1, 4'hB, 0, 0,  1, 1, 16'h4321, 3'd4, 2'd2));
    q.push_back(mk(1, 4'hC, 0, 0,  0, 1, 16'h4321, 3'd4, 2'd2));
    q.push_back(mk(1, 4'hC, 0, 0,  0, 1, 16'h4321, 3'd4, 2'd2));
    q.push_back(mk(1, 4'hC, 0, 1,  0, 1, 16'h4321, 3'd4, 2'd2));
    q.push_back(mk(1, 4'hC, 0, 1,  1, 1, 16'h8765, 3'd4, 2'd1));
    q.push_back(mk(0, 4'h0, 0, 1,  1, 1, 16'hCBA9, 3'd4, 2'd1));
    q.push_back(mk(0, 4'h0, 0, 0,  1, 0, 16'h0000, 3'd0, 2'd0));
    run_seq("bp", q);

    // Flush with FIFO full and fill=1 parks in FLUSH_PEND until a pop frees a slot
    q = {};
    for (int i = 0; i < 8; i++)
      q.push_back(mk(1, 4'(i + 1), 0, 0, 1, (i >= 4), 16'h4321, 3'd4, (i >= 4) ? 2'd1 : 2'd0));
    q.push_back(mk(1, 4'hD, 0, 0,  1, 1, 16'h4321, 3'd4, 2'd2));
    q.push_back(mk(0, 4'h0, 1, 0,  1, 1, 16'h4321, 3'd4, 2'd2));
    q.push_back(mk(1, 4'hE, 0, 0,  0, 1, 16'h4321, 3'd4, 2'd2));
    q.push_back(mk(1, 4'hE, 1, 0,  0, 1, 16'h4321, 3'd4, 2'd2));
    q.push_back(mk(0, 4'h0, 0, 1,  0, 1, 16'h4321, 3'd4, 2'd2));
    q.push_back(mk(0, 4'h0, 0, 0,  0, 1, 16'h8765, 3'd4, 2'd1));
    q.push_back(mk(0, 4'h0, 0, 1,  1, 1, 16'h8765, 3'd4, 2'd2));
    q.push_back(mk(0, 4'h0, 0, 1,  1, 1, 16'h000D, 3'd1, 2'd1));
    q.push_back(mk(0, 4'h0, 0, 0,  1, 0, 16'h0000, 3'd0, 2'd0));
    run_seq("fpend", q);

    // Flush coincident with the completing nibble: one full word, nothing after it
    q = {};
    q.push_back(mk(1, 4'h5, 0, 0,  1, 0, 16'h0000, 3'd0, 2'd0));
    q.push_back(mk(1, 4'h6, 0, 0,  1, 0, 16'h0000, 3'd0, 2'd0));
    q.push_back(mk(1, 4'h7, 0, 0,  1, 0, 16'h0000, 3'd0, 2'd0));
    q.push_back(mk(1, 4'h8, 1, 0,  1, 0, 16'h0000, 3'd0, 2'd0));
    q.push_back(mk(0, 4'h0, 0, 0,  1, 1, 16'h8765, 3'd4, 2'd1));
    q.push_back(mk(0, 4'h0, 0, 1,  1, 1, 16'h8765, 3'd4, 2'd1));
    q.push_back(mk(0, 4'h0, 0, 0,  1, 0, 16'h0000, 3'd0, 2'd0));
    q.push_back(mk(0, 4'h0, 0, 0,  1, 0, 16'h0000, 3'd0, 2'd0));
    run_seq("flush_last", q);

    // Reset with one word queued and two nibbles held
    q = {};
    q.push_back(mk(1, 4'h1, 0, 0,  1, 0, 16'h0000, 3'd0, 2'd0));
    q.push_back(mk(1, 4'h2, 0, 0,  1, 0, 16'h0000, 3'd0, 2'd0));
    q.push_back(mk(1, 4'h3, 0, 0,  1, 0, 16'h0000, 3'd0, 2'd0));
    q.push_back(mk(1, 4'h4, 0, 0,  1, 0, 16'h0000, 3'd0, 2'd0));
    q.push_back(mk(1, 4'h5, 0, 0,  1, 1, 16'h4321, 3'd4, 2'd1));
    q.push_back(mk(1, 4'h6, 0, 0,  1, 1, 16'h4321, 3'd4, 2'd1));
    run_seq("pre_rst", q);
    bus.nib_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset_outs("mid_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q = {};
    q.push_back(mk(0, 4'h0, 0, 1,  1, 0, 16'h0000, 3'd0, 2'd0));
    q.push_back(mk(1, 4'h9, 0, 1,  1, 0, 16'h0000, 3'd0, 2'd0));
    q.push_back(mk(1, 4'hA, 0, 1,  1, 0, 16'h0000, 3'd0, 2'd0));
    q.push_back(mk(1, 4'hB, 0, 1,  1, 0, 16'h0000, 3'd0, 2'd0));
    q.push_back(mk(1, 4'hC, 0, 1,  1, 0, 16'h0000, 3'd0, 2'd0));
    q.push_back(mk(0, 4'h0, 0, 1,  1, 1, 16'hCBA9, 3'd4, 2'd1));
    q.push_back(mk(0, 4'h0, 0, 1,  1, 0, 16'h0000, 3'd0, 2'd0));
    q.push_back(mk(0, 4'h0, 0, 1,  1, 0, 16'h0000, 3'd0, 2'd0));
    run_seq("post_rst", q);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
